// File: rtl/regfile_write_arbiter.sv
// Purpose : round-robin share of the single register-file write port among NUM_REQ writeback sources.
// Latency : 1 cycle from req_valid&req_ready to RegWrite/addD/dataD; x0 writes are absorbed, never written.
// Backpr. : valid/ready per source; one non-x0 grant per cycle, x0 always accepted (held off by wb_stall).
//
// Optional feature macro: REGARB_STALL_EN (adds wb_stall input that freezes acceptance).
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-low reset
//   req_valid     - per-source write request
//   req_addr      - per-source destination register, source i at [i*ADDR_W +: ADDR_W]
//   req_data      - per-source write data, source i at [i*DATA_W +: DATA_W]
//   req_ready     - per-source accept (transfer = valid & ready)
//   wb_stall      - (REGARB_STALL_EN only) blocks every accept while high
//   RegWrite      - registered register-file write enable
//   addD, dataD   - registered write address / data (hold when idle)
//   grant_id      - source index of the current write (meaningful when RegWrite=1)
//   conflict_cnt  - saturating count of cycles with two or more non-x0 requesters
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef REGARB_STALL_EN
    input  logic                      wb_stall,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         addD,
    output logic [DATA_W-1:0]         dataD,
    output logic [ID_W-1:0]           grant_id,
    output logic [CNT_W-1:0]          conflict_cnt
);

    logic stall;
`ifdef REGARB_STALL_EN
    assign stall = wb_stall;
`else
    assign stall = 1'b0;
`endif

    // State
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] addd_q, addd_d;
    logic [DATA_W-1:0] datad_q, datad_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    // Per-source decode
    logic [NUM_REQ-1:0] is_x0;
    logic [NUM_REQ-1:0] cand;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    always_comb begin
        is_x0 = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
            is_x0[i]    = req_valid[i] && (addr_arr[i] == '0);
            cand[i]     = req_valid[i] && (addr_arr[i] != '0);
        end
    end

    // Round-robin pick. Descending scan leaves the lowest candidate at or above
    // rr_ptr in idx_hi and the lowest candidate overall in idx_lo; the latter
    // is the wrapped-around winner when nothing sits at or above the pointer.
    logic            found_hi, found_lo;
    logic [ID_W-1:0] idx_hi, idx_lo, grant_idx;

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found_lo = 1'b1;
                idx_lo   = ID_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = ID_W'(i);
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_lo;
    end

    logic              grant_fire;
    logic              multi_cand;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign grant_fire = found_lo && !stall;
    // Two or more bits set: clearing the lowest set bit leaves something.
    assign multi_cand = |(cand & (cand - NUM_REQ'(1)));

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_addr = addr_arr[i];
                sel_data = data_arr[i];
            end
        end
    end

    // Ready: x0 requests are swallowed unconditionally, plus the single winner.
    // Gated by rst so nothing is accepted while the write port is in reset.
    always_comb begin
        req_ready = '0;
        if (rst && !stall) begin
            req_ready = is_x0;
            if (found_lo) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_idx == ID_W'(i)) begin
                        req_ready[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        regwrite_d     = 1'b0;
        addd_d         = addd_q;
        datad_d        = datad_q;
        grant_id_d     = grant_id_q;
        rr_ptr_d       = rr_ptr_q;
        conflict_cnt_d = conflict_cnt_q;
        if (grant_fire) begin
            regwrite_d = 1'b1;
            addd_d     = sel_addr;
            datad_d    = sel_data;
            grant_id_d = grant_idx;
            rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
        if (multi_cand && !stall && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q     <= 1'b0;
            addd_q         <= '0;
            datad_q        <= '0;
            grant_id_q     <= '0;
            rr_ptr_q       <= '0;
            conflict_cnt_q <= '0;
        end else begin
            regwrite_q     <= regwrite_d;
            addd_q         <= addd_d;
            datad_q        <= datad_d;
            grant_id_q     <= grant_id_d;
            rr_ptr_q       <= rr_ptr_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign RegWrite     = regwrite_q;
    assign addD         = addd_q;
    assign dataD        = datad_q;
    assign grant_id     = grant_id_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose : directed self-checking bench for regfile_write_arbiter (3 sources, 4-bit contention counter).
// Latency : inputs driven 1 time unit after posedge; registered outputs checked 1 unit after the next posedge.
// Backpr. : sources follow valid/ready; valid is withdrawn by the bench once a transfer completes.
module tb_regfile_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr  = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      RegWrite;
    logic [ADDR_W-1:0]         addD;
    logic [DATA_W-1:0]         dataD;
    logic [1:0]                grant_id;
    logic [CNT_W-1:0]          conflict_cnt;
`ifdef REGARB_STALL_EN
    logic                      wb_stall = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
`ifdef REGARB_STALL_EN
        .wb_stall     (wb_stall),
`endif
        .req_ready    (req_ready),
        .RegWrite     (RegWrite),
        .addD         (addD),
        .dataD        (dataD),
        .grant_id     (grant_id),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_valid[i]               = v;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [1:0] g, input logic [CNT_W-1:0] c);
        chk({tag, "_we"},  64'(RegWrite), 64'(we));
        chk({tag, "_add"}, 64'(addD), 64'(a));
        chk({tag, "_dat"}, 64'(dataD), 64'(d));
        chk({tag, "_gid"}, 64'(grant_id), 64'(g));
        chk({tag, "_cnt"}, 64'(conflict_cnt), 64'(c));
    endtask

    initial begin
        // Reset held with every source requesting
        for (int i = 0; i < NUM_REQ; i++) set_src(i, 1'b1, ADDR_W'(i + 1), 32'hA0A0_0000 | i);
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'b000);
        chk_wr("rst", 1'b0, '0, '0, 2'd0, '0);

        rst = 1'b1;
        #1;
        chk("rel_ready", 64'(req_ready), 64'b001);

        // Round robin with all three continuously valid
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_wr("rr", 1'b1, ADDR_W'(k % 3 + 1), 32'hA0A0_0000 | (k % 3), 2'(k % 3), CNT_W'(k + 1));
            chk("rr_ready", 64'(req_ready), 64'(1 << ((k + 1) % 3)));
        end
        req_valid = '0;
        tick();
        chk_wr("idle", 1'b0, 5'd3, 32'hA0A0_0002, 2'd2, 4'd6);

        // Single source 1
        set_src(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("single_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        chk_wr("single", 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1, 4'd6);
        tick();
        chk("single_off", 64'(RegWrite), 64'd0);

        // x0 absorb together with a real write (rr_ptr is 2 here)
        set_src(0, 1'b1, 5'd0, 32'h1111_1111);
        set_src(2, 1'b1, 5'd7, 32'h7777_7777);
        #1;
        chk("x0mix_ready", 64'(req_ready), 64'b101);
        tick();
        req_valid = '0;
        chk_wr("x0mix", 1'b1, 5'd7, 32'h7777_7777, 2'd2, 4'd6);
        tick();
        chk("x0mix_off", 64'(RegWrite), 64'd0);

        // x0 alone: accepted, never written, pointer untouched
        set_src(1, 1'b1, 5'd0, 32'h2222_2222);
        #1;
        chk("x0only_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        chk_wr("x0only", 1'b0, 5'd7, 32'h7777_7777, 2'd2, 4'd6);

        // rr_ptr must be 0: sources 0 and 2 contend, 0 wins
        set_src(0, 1'b1, 5'd10, 32'h0000_000A);
        set_src(2, 1'b1, 5'd11, 32'h0000_000B);
        #1;
        chk("ptr0_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid[0] = 1'b0;
        chk_wr("ptr0", 1'b1, 5'd10, 32'h0000_000A, 2'd0, 4'd7);
        #1;
        chk("ptr0_ready2", 64'(req_ready), 64'b100);
        tick();
        req_valid = '0;
        chk_wr("ptr0b", 1'b1, 5'd11, 32'h0000_000B, 2'd2, 4'd7);

        // Same destination from two sources, written in grant order
        set_src(0, 1'b1, 5'd4, 32'hAAAA_0000);
        set_src(1, 1'b1, 5'd4, 32'hBBBB_0000);
        tick();
        req_valid[0] = 1'b0;
        chk_wr("same_a", 1'b1, 5'd4, 32'hAAAA_0000, 2'd0, 4'd8);
        tick();
        req_valid = '0;
        chk_wr("same_b", 1'b1, 5'd4, 32'hBBBB_0000, 2'd1, 4'd8);

        // Saturation: 20 contention cycles from a count of 8
        for (int i = 0; i < NUM_REQ; i++) set_src(i, 1'b1, ADDR_W'(i + 1), 32'hC0C0_0000 | i);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("sat_cnt", 64'(conflict_cnt), 64'((9 + k > 15) ? 15 : 9 + k));
        end
        chk("sat_we", 64'(RegWrite), 64'd1);

        // Reset mid-operation: pending write dropped at once, pointer back to 0
        rst = 1'b0;
        #1;
        chk("mrst_we", 64'(RegWrite), 64'd0);
        chk("mrst_ready", 64'(req_ready), 64'b000);
        chk("mrst_cnt", 64'(conflict_cnt), 64'd0);
        chk("mrst_add", 64'(addD), 64'd0);
        rst = 1'b1;
        #1;
        chk("mrst_rel_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        chk_wr("mrst_first", 1'b1, 5'd1, 32'hC0C0_0000, 2'd0, 4'd1);
        tick();
        chk("mrst_idle", 64'(RegWrite), 64'd0);

`ifdef REGARB_STALL_EN
        // Stall: three cycles of no accept, then src0 granted when stall drops
        wb_stall = 1'b1;
        set_src(0, 1'b1, 5'd12, 32'h0000_C0DE);
        set_src(1, 1'b1, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 64'(req_ready), 64'b000);
            tick();
            chk("stall_we", 64'(RegWrite), 64'd0);
            chk("stall_cnt", 64'(conflict_cnt), 64'd1);
        end
        wb_stall = 1'b0;
        req_valid[1] = 1'b0;
        #1;
        chk("unstall_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        chk_wr("unstall", 1'b1, 5'd12, 32'h0000_C0DE, 2'd0, 4'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
